// File: rtl/svm_coef_loader.sv
// svm_coef_loader: packs a narrow coefficient stream into N_ROW RAM rows of N_COEF words,
// writes them in address order, then captures one bias word and pulses b_load/done.
// Optional build macro SVM_COEF_LOADER_READBACK_EN adds a read-back check after every row write.
module svm_coef_loader #(
   parameter int unsigned COEF_W = 12,
   parameter int unsigned N_COEF = 105,
   parameter int unsigned N_ROW  = 36,
   parameter int unsigned ADDR_W = 6,
   localparam int unsigned RAM_DW = COEF_W * N_COEF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [COEF_W-1:0] s_data_i,
   input  logic              s_valid_i,
   output logic              s_ready_o,
   output logic [ADDR_W-1:0] addr_a_o,
   output logic              write_en_o,
   output logic [RAM_DW-1:0] i_data_a_o,
   input  logic [RAM_DW-1:0] o_data_a_i,
   output logic [COEF_W-1:0] bias_o,
   output logic              b_load_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              rd_err_o
);

   localparam int unsigned CNT_W = $clog2(N_COEF);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLoad  = 3'd1;
   localparam logic [2:0] StWrite = 3'd2;
   localparam logic [2:0] StBias  = 3'd3;
`ifdef SVM_COEF_LOADER_READBACK_EN
   localparam logic [2:0] StChk1  = 3'd4;
   localparam logic [2:0] StChk2  = 3'd5;
`endif

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] row_q, row_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [RAM_DW-1:0] pack_q, pack_d;
   logic [COEF_W-1:0] bias_q, bias_d;
   logic              s_ready_q, s_ready_d;
   logic              b_load_q, b_load_d;
   logic              done_q, done_d;
   logic              rd_err_q, rd_err_d;
   logic              accept;
   logic              row_adv;

   assign accept = s_valid_i & s_ready_q;

   // Next-state decode: word packing, row sequencing and bias capture.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      row_d    = row_q;
      addr_d   = addr_q;
      pack_d   = pack_q;
      bias_d   = bias_q;
      b_load_d = 1'b0;
      done_d   = 1'b0;
      rd_err_d = rd_err_q;
      row_adv  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d  = StLoad;
               row_d    = '0;
               cnt_d    = '0;
               rd_err_d = 1'b0;
            end
         end
         StLoad: begin
            if (accept) begin
               pack_d[cnt_q*COEF_W +: COEF_W] = s_data_i;
               if (cnt_q == CNT_W'(N_COEF - 1)) begin
                  state_d = StWrite;
                  addr_d  = row_q;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
`ifdef SVM_COEF_LOADER_READBACK_EN
         StWrite: state_d = StChk1;
         StChk1:  state_d = StChk2;
         StChk2: begin
            // RAM read data for addr_a arrives one cycle after the address.
            if (o_data_a_i != pack_q) rd_err_d = 1'b1;
            row_adv = 1'b1;
         end
`else
         StWrite: row_adv = 1'b1;
`endif
         StBias: begin
            if (accept) begin
               bias_d   = s_data_i;
               b_load_d = 1'b1;
               done_d   = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (row_adv) begin
         if (row_q == ADDR_W'(N_ROW - 1)) begin
            state_d = StBias;
         end else begin
            state_d = StLoad;
            row_d   = row_q + ADDR_W'(1);
         end
      end
      s_ready_d = (state_d == StLoad) || (state_d == StBias);
   end

   // State and datapath registers; RAM contents are not ours to clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         row_q     <= '0;
         addr_q    <= '0;
         pack_q    <= '0;
         bias_q    <= '0;
         s_ready_q <= 1'b0;
         b_load_q  <= 1'b0;
         done_q    <= 1'b0;
         rd_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         row_q     <= row_d;
         addr_q    <= addr_d;
         pack_q    <= pack_d;
         bias_q    <= bias_d;
         s_ready_q <= s_ready_d;
         b_load_q  <= b_load_d;
         done_q    <= done_d;
         rd_err_q  <= rd_err_d;
      end
   end

   assign s_ready_o  = s_ready_q;
   assign addr_a_o   = addr_q;
   assign write_en_o = (state_q == StWrite);
   assign i_data_a_o = pack_q;
   assign bias_o     = bias_q;
   assign b_load_o   = b_load_q;
   assign done_o     = done_q;
   assign busy_o     = (state_q != StIdle);

`ifdef SVM_COEF_LOADER_READBACK_EN
   assign rd_err_o = rd_err_q;
`else
   logic unused_rb;
   assign unused_rb = ^{o_data_a_i, rd_err_q};
   assign rd_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_svm_coef_loader.sv
// Self-checking bench for svm_coef_loader: behavioural RAM, stream driver, reference rows.
module tb_svm_coef_loader;

   localparam int COEF_W  = 12;
   localparam int N_COEF  = 105;
   localparam int N_ROW   = 36;
   localparam int ADDR_W  = 6;
   localparam int RAM_DW  = COEF_W * N_COEF;
   localparam int N_WORDS = N_ROW * N_COEF + 1;
`ifdef SVM_COEF_LOADER_READBACK_EN
   localparam int EXP_DONE = N_ROW * (N_COEF + 1) + 2 + 2 * N_ROW;
   localparam bit RB = 1'b1;
`else
   localparam int EXP_DONE = N_ROW * (N_COEF + 1) + 2;
   localparam bit RB = 1'b0;
`endif
   localparam int LIMIT = 3 * EXP_DONE;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [COEF_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;
   logic [ADDR_W-1:0] addr_a;
   logic              write_en;
   logic [RAM_DW-1:0] i_data_a;
   logic [RAM_DW-1:0] o_data_a;
   logic [COEF_W-1:0] bias;
   logic              b_load;
   logic              busy;
   logic              done;
   logic              rd_err;

   int checks = 0;
   int failures = 0;

   logic [COEF_W-1:0] stim [N_WORDS];
   logic [RAM_DW-1:0] mem [64];
   bit                corrupt = 1'b0;

   int wr_log [$];
   bit rd_log [$];
   int n_done, n_bload, rdy_err, coinc_err;

   always #5 clk = ~clk;

   svm_coef_loader dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .start_i    (start),
      .s_data_i   (s_data),
      .s_valid_i  (s_valid),
      .s_ready_o  (s_ready),
      .addr_a_o   (addr_a),
      .write_en_o (write_en),
      .i_data_a_o (i_data_a),
      .o_data_a_i (o_data_a),
      .bias_o     (bias),
      .b_load_o   (b_load),
      .busy_o     (busy),
      .done_o     (done),
      .rd_err_o   (rd_err)
   );

   // Synchronous RAM with one-cycle read latency; optionally corrupts bit 0 of row 7.
   always @(posedge clk) begin
      if (write_en) mem[addr_a] <= (corrupt && addr_a == 6'd7) ? (i_data_a ^ 1) : i_data_a;
      o_data_a <= mem[addr_a];
   end

   // Passive monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (write_en) begin
            wr_log.push_back(int'(addr_a));
            rd_log.push_back(rd_err);
            if (s_ready) rdy_err++;
         end
         if (done) n_done++;
         if (b_load) n_bload++;
         if (b_load !== done) coinc_err++;
      end
   end

   function automatic logic [RAM_DW-1:0] exp_row(input int r);
      logic [RAM_DW-1:0] v;
      for (int c = 0; c < N_COEF; c++) v[c*COEF_W +: COEF_W] = stim[r*N_COEF + c];
      return v;
   endfunction

   task automatic clear_log();
      wr_log.delete();
      rd_log.delete();
      n_done = 0; n_bload = 0; rdy_err = 0; coinc_err = 0;
   endtask

   task automatic fill_random();
      for (int k = 0; k < N_WORDS; k++) stim[k] = COEF_W'($urandom);
   endtask

   // Pulses start, streams stim[] and returns the cycle (start cycle = 0) done was seen.
   task automatic drive_load(input bit toggle, input bit extra, input int abort_idx,
                             output int done_cyc, output bit done_rderr);
      int idx;
      int cyc;
      bit rdy;
      idx = 0; cyc = 0; done_cyc = -1; done_rderr = 1'b0; rdy = 1'b0;
      @(negedge clk);
      start = 1'b1;
      s_valid = 1'b0;
      forever begin
         @(posedge clk);
         if (s_valid && rdy) idx++;
         @(negedge clk);
         cyc++;
         start = extra && (cyc == 10 || cyc == 2000);
         rdy = s_ready;
         if (done && done_cyc < 0) begin
            done_cyc = cyc;
            done_rderr = rd_err;
         end
         if (idx == abort_idx) break;
         if (cyc >= LIMIT || (done_cyc >= 0 && cyc >= done_cyc + 5)) break;
         s_valid = (idx < N_WORDS) && (!toggle || cyc[0]);
         s_data  = s_valid ? stim[idx] : COEF_W'($urandom);
      end
      start = 1'b0;
      s_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({s_ready, addr_a, write_en, bias, b_load, busy, done, rd_err} !== '0 || i_data_a !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got ready=%b addr=%0d we=%b bias=%h bl=%b busy=%b done=%b err=%b, required all 0",
                  s_ready, addr_a, write_en, bias, b_load, busy, done, rd_err);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || s_ready !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset: got busy=%b ready=%b, required 0 0", busy, s_ready);
      end
   endtask

   task automatic test_continuous();
      int dc; bit de; int bad;
      for (int k = 0; k < N_WORDS - 1; k++) stim[k] = COEF_W'(k % 4096);
      stim[N_WORDS-1] = 12'h800;
      clear_log();
      drive_load(1'b0, 1'b0, -1, dc, de);
      checks++;
      if (dc != EXP_DONE) begin
         failures++; $display("FAIL cont_done_cycle: got %0d required %0d", dc, EXP_DONE);
      end
      checks++;
      if (wr_log.size() != N_ROW) begin
         failures++; $display("FAIL cont_write_count: got %0d required %0d", wr_log.size(), N_ROW);
      end
      bad = 0;
      for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] != i) bad++;
      checks++;
      if (bad != 0) begin
         failures++; $display("FAIL cont_write_order: got %0d out-of-order addresses required 0", bad);
      end
      for (int r = 0; r < N_ROW; r++) begin
         checks++;
         if (mem[r] !== exp_row(r)) begin
            failures++;
            for (int c = 0; c < N_COEF; c++)
               if (mem[r][c*COEF_W +: COEF_W] !== 12'((r*N_COEF + c) % 4096)) begin
                  $display("FAIL cont_row%0d slice %0d: got %h required %h", r, c,
                           mem[r][c*COEF_W +: COEF_W], 12'((r*N_COEF + c) % 4096));
                  break;
               end
         end
      end
      checks++;
      if (bias !== 12'h800 || n_bload != 1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL cont_bias: got bias=%h b_loads=%0d busy=%b required 800 1 0", bias, n_bload, busy);
      end
   endtask

   task automatic test_toggle_valid();
      int dc; bit de;
      fill_random();
      clear_log();
      drive_load(1'b1, 1'b0, -1, dc, de);
      checks++;
      if (dc < 0 || n_done != 1 || wr_log.size() != N_ROW) begin
         failures++;
         $display("FAIL toggle_progress: got done_cyc=%0d dones=%0d writes=%0d required >0 1 %0d",
                  dc, n_done, wr_log.size(), N_ROW);
      end
      checks++;
      if (rdy_err != 0) begin
         failures++; $display("FAIL toggle_ready_in_write: got %0d required 0", rdy_err);
      end
      for (int r = 0; r < N_ROW; r++) begin
         checks++;
         if (mem[r] !== exp_row(r)) begin
            failures++;
            $display("FAIL toggle_row%0d: got[47:0]=%h required[47:0]=%h", r, mem[r][47:0], exp_row(r) >> 0);
         end
      end
      checks++;
      if (bias !== stim[N_WORDS-1]) begin
         failures++; $display("FAIL toggle_bias: got %h required %h", bias, stim[N_WORDS-1]);
      end
   endtask

   task automatic test_extra_start();
      int dc; bit de;
      fill_random();
      clear_log();
      drive_load(1'b0, 1'b1, -1, dc, de);
      checks++;
      if (wr_log.size() != N_ROW || n_done != 1 || dc != EXP_DONE) begin
         failures++;
         $display("FAIL extra_start: got writes=%0d dones=%0d done_cyc=%0d required %0d 1 %0d",
                  wr_log.size(), n_done, dc, N_ROW, EXP_DONE);
      end
   endtask

   task automatic test_abort_restart();
      int dc; bit de;
      fill_random();
      clear_log();
      drive_load(1'b0, 1'b0, 5 * N_COEF + 50, dc, de);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({s_ready, addr_a, write_en, bias, b_load, busy, done, rd_err} !== '0 || i_data_a !== '0) begin
         failures++;
         $display("FAIL abort_outputs: got ready=%b addr=%0d we=%b bias=%h bl=%b busy=%b done=%b, required all 0",
                  s_ready, addr_a, write_en, bias, b_load, busy, done);
      end
      checks++;
      if (n_done != 0 || wr_log.size() != 5) begin
         failures++;
         $display("FAIL abort_partial: got dones=%0d writes=%0d required 0 5", n_done, wr_log.size());
      end
      @(negedge clk);
      rst_n = 1'b1;
      fill_random();
      clear_log();
      drive_load(1'b0, 1'b0, -1, dc, de);
      checks++;
      if (wr_log.size() != N_ROW || wr_log[0] != 0 || n_done != 1) begin
         failures++;
         $display("FAIL restart: got writes=%0d first=%0d dones=%0d required %0d 0 1",
                  wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : -1, n_done, N_ROW);
      end
      for (int r = 0; r < N_ROW; r++) begin
         checks++;
         if (mem[r] !== exp_row(r)) begin
            failures++;
            $display("FAIL restart_row%0d: got[47:0]=%h required[47:0]=%h", r, mem[r][47:0], exp_row(r) >> 0);
         end
      end
   endtask

   task automatic test_readback();
      int dc; bit de; int bad;
      fill_random();
      corrupt = 1'b1;
      clear_log();
      drive_load(1'b0, 1'b0, -1, dc, de);
      corrupt = 1'b0;
      bad = 0;
      // Error appears after row 7's check, so it is first visible at row 8's write.
      for (int r = 0; r < rd_log.size(); r++) if (rd_log[r] !== (RB && r >= 8)) bad++;
      checks++;
      if (bad != 0 || rd_log.size() != N_ROW) begin
         failures++;
         $display("FAIL readback_corrupt_trace: got %0d wrong of %0d rows required 0 of %0d", bad, rd_log.size(), N_ROW);
      end
      checks++;
      if (de !== RB || rd_err !== RB) begin
         failures++;
         $display("FAIL readback_sticky: got at_done=%b after=%b required %b", de, rd_err, RB);
      end
      fill_random();
      clear_log();
      drive_load(1'b0, 1'b0, -1, dc, de);
      bad = 0;
      for (int r = 0; r < rd_log.size(); r++) if (rd_log[r] !== 1'b0) bad++;
      checks++;
      if (bad != 0 || de !== 1'b0 || rd_err !== 1'b0) begin
         failures++;
         $display("FAIL readback_clean: got bad_rows=%0d at_done=%b required 0 0", bad, de);
      end
   endtask

   task automatic test_back_to_back();
      int dc; bit de;
      fill_random();
      clear_log();
      drive_load(1'b0, 1'b0, -1, dc, de);
      checks++;
      if (dc != EXP_DONE || bias !== stim[N_WORDS-1]) begin
         failures++;
         $display("FAIL b2b_bias: got done_cyc=%0d bias=%h required %0d %h", dc, bias, EXP_DONE, stim[N_WORDS-1]);
      end
      checks++;
      if (coinc_err != 0 || n_bload != 1 || n_done != 1 || rdy_err != 0) begin
         failures++;
         $display("FAIL b2b_strobes: got split=%0d b_loads=%0d dones=%0d ready_in_write=%0d required 0 1 1 0",
                  coinc_err, n_bload, n_done, rdy_err);
      end
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_toggle_valid();
      test_extra_start();
      test_abort_restart();
      test_readback();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
